pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- Generates per-stage enable and flush, PC enable and PC source select.
- Inputs: cache handshakes (ihit/dhit), load-use hazard detection, branch/jump resolution and halt drain.
- Sits beside the datapath; the pipeline registers consume en_N/flush_N, and the PC mux consumes pc_en/pc_sel.

Parameters:
REG_W, 5, register-index width.
CNT_W, 16, width of stall performance counter.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  reset, synchronous, active-low.
ihit  in  1  instruction fetch complete this cycle.
dhit  in  1  data access complete this cycle.
mem_dREN  in  1  MEM-stage load.
mem_dWEN  in  1  MEM-stage store.
ex_dREN  in  1  EX-stage instruction is a load.
ex_wsel  in  REG_W  EX-stage destination register.
id_rs  in  REG_W  ID-stage source rs.
id_rt  in  REG_W  ID-stage source rt.
id_uses_rt  in  1  ID-stage instruction reads rt.
ex_jump  in  1  j/jal/JR resolved in EX.
mem_br_taken  in  1  beq/bne taken, resolved in MEM.
mem_halt  in  1  halt instruction in MEM.
wb_halt  in  1  halt instruction in WB.
en_1..en_4  out  1 each  load enable for IF/ID, ID/EX, EX/MEM, MEM/WB.
flush_1..flush_3  out  1 each  zero IF/ID, ID/EX, EX/MEM at next edge; flush overrides en.
pc_en  out  1  PC update enable.
pc_sel  out  2  0=PC+4, 1=jump target, 2=branch target, 3=reserved (never driven).
halt  out  1  core halted, sticky.
stall_cnt  out  CNT_W  cycles with pc_en=0 while not HALTED.

Behaviour:
- States: RUN, DWAIT, DRAIN, HALTED. A registered state; all outputs are combinational from state and inputs.
- Reset (nRST=0 at edge): state=RUN, stall_cnt=0, halt=0.
  - While nRST=0, outputs are forced to en_*=0, flush_*=1, pc_en=0, pc_sel=0.
  - Reset mid-DWAIT or mid-DRAIN aborts cleanly to RUN.
- mem_acc = mem_dREN|mem_dWEN.
- Decision priority each cycle in RUN: dmem wait > halt > branch > jump > load-use > ifetch miss > normal.
- dmem wait: mem_acc & !dhit → all en=0, pc_en=0, no flush; next state DWAIT.
- DWAIT: freeze all while !dhit.
  - On dhit: all en=1, pc_en=ihit, flush_1=!ihit; return to RUN.
  - Exactly one advance per completed access.
- halt: mem_halt (RUN, not waiting on dmem) → pc_en=0, flush_1=flush_2=flush_3=1, en_4=1; next state DRAIN.
- DRAIN: pc_en=0, flush_1..3=1, en_4=1; on wb_halt → HALTED.
- HALTED: all en=0, flush=0, pc_en=0, halt=1; leaves only on reset.
- branch: mem_br_taken → flush_1..3=1, pc_sel=2, pc_en=1, en_4=1.
  - Overrides a simultaneous ex_jump, which is younger and squashed.
- jump: ex_jump → flush_1=flush_2=1, pc_sel=1, pc_en=1, en_3=en_4=1.
- load-use: ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)):
  - pc_en=0, en_1=0, flush_2=1 (bubble), en_3=en_4=1.
  - Register 0 never triggers a stall.
- ifetch miss: !ihit → pc_en=0, flush_1=1, en_2..4=1.
- normal: all en=1, flush=0, pc_en=1, pc_sel=0.
- pc_sel=0 whenever pc_en=0 or a redirect is absent.
- stall_cnt: +1 on each edge where state≠HALTED, nRST=1 and pc_en=0.
  - Saturates at 2^CNT_W−1; holds in HALTED.
- Branch/jump redirect is ignored while a dmem wait freezes the pipe; it is taken on the advance cycle if still asserted.

Test Plan:
- Reset release with ihit=1, no hazards → cycle 1: en_1..4=1, pc_en=1, pc_sel=0, stall_cnt=0, halt=0.
- mem_dREN=1, dhit=0 for 3 cycles then dhit=1 → en_*=0 for 3 cycles (state DWAIT), then one advance cycle; stall_cnt=3.
- ex_dREN=1, ex_wsel=5, id_rt=5, id_uses_rt=1 → pc_en=0, en_1=0, flush_2=1, en_3=en_4=1 for one cycle.
  - Repeat with ex_wsel=0 → no stall.
- mem_br_taken=1 and ex_jump=1 same cycle → pc_sel=2, flush_1..3=1; a jump alone → pc_sel=1, flush_1=flush_2=1, flush_3=0.
- mem_halt=1, wb_halt=1 two cycles later → DRAIN for 2 cycles with pc_en=0, then halt=1 sticky.
  - stall_cnt frozen; nRST=0 clears halt and returns to RUN.
- Force 70000 ifetch-miss cycles with CNT_W=16 → stall_cnt saturates at 65535.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-stage enable/flush, PC enable and PC source select.
// Handles dmem waits, halt drain, branch/jump redirect, load-use and ifetch stalls.
module pipeline_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_jump,
  input  logic             mem_br_taken,
  input  logic             mem_halt,
  input  logic             wb_halt,
  output logic             en_1,
  output logic             en_2,
  output logic             en_3,
  output logic             en_4,
  output logic             flush_1,
  output logic             flush_2,
  output logic             flush_3,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_acc;
  logic load_use;
  logic dwait_go;
  logic halt_go;
  logic br_go;
  logic jmp_go;
  logic lu_go;
  logic miss_go;

  // Mutually exclusive decisions, strongest first.
  always_comb begin
    mem_acc  = mem_dREN | mem_dWEN;
    load_use = ex_dREN && (ex_wsel != '0) &&
               ((ex_wsel == id_rs) ||
                (id_uses_rt && (ex_wsel == id_rt)));
    dwait_go = mem_acc & ~dhit;
    halt_go  = ~dwait_go & mem_halt;
    br_go    = ~dwait_go & ~mem_halt & mem_br_taken;
    jmp_go   = ~dwait_go & ~mem_halt & ~mem_br_taken & ex_jump;
    lu_go    = ~dwait_go & ~mem_halt & ~mem_br_taken & ~ex_jump
               & load_use;
    miss_go  = ~dwait_go & ~mem_halt & ~mem_br_taken & ~ex_jump
               & ~load_use & ~ihit;
  end

  always_comb begin
    en_1    = 1'b0;
    en_2    = 1'b0;
    en_3    = 1'b0;
    en_4    = 1'b0;
    flush_1 = 1'b0;
    flush_2 = 1'b0;
    flush_3 = 1'b0;
    pc_en   = 1'b0;
    pc_sel  = 2'd0;
    state_d = state_q;
    if (!nRST) begin
      flush_1 = 1'b1;
      flush_2 = 1'b1;
      flush_3 = 1'b1;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          unique case (1'b1)
            dwait_go: state_d = DWAIT;
            halt_go: begin
              flush_1 = 1'b1;
              flush_2 = 1'b1;
              flush_3 = 1'b1;
              en_4    = 1'b1;
              state_d = DRAIN;
            end
            br_go: begin
              flush_1 = 1'b1;
              flush_2 = 1'b1;
              flush_3 = 1'b1;
              en_4    = 1'b1;
              pc_en   = 1'b1;
              pc_sel  = 2'd2;
            end
            jmp_go: begin
              flush_1 = 1'b1;
              flush_2 = 1'b1;
              en_3    = 1'b1;
              en_4    = 1'b1;
              pc_en   = 1'b1;
              pc_sel  = 2'd1;
            end
            lu_go: begin
              flush_2 = 1'b1;
              en_3    = 1'b1;
              en_4    = 1'b1;
            end
            miss_go: begin
              flush_1 = 1'b1;
              en_2    = 1'b1;
              en_3    = 1'b1;
              en_4    = 1'b1;
            end
            default: begin
              en_1  = 1'b1;
              en_2  = 1'b1;
              en_3  = 1'b1;
              en_4  = 1'b1;
              pc_en = 1'b1;
            end
          endcase
        end
        DWAIT: begin
          // Redirects held off during the wait take effect on the advance.
          if (dhit) begin
            state_d = RUN;
            if (mem_br_taken) begin
              flush_1 = 1'b1;
              flush_2 = 1'b1;
              flush_3 = 1'b1;
              en_4    = 1'b1;
              pc_en   = 1'b1;
              pc_sel  = 2'd2;
            end else if (ex_jump) begin
              flush_1 = 1'b1;
              flush_2 = 1'b1;
              en_3    = 1'b1;
              en_4    = 1'b1;
              pc_en   = 1'b1;
              pc_sel  = 2'd1;
            end else begin
              en_1    = 1'b1;
              en_2    = 1'b1;
              en_3    = 1'b1;
              en_4    = 1'b1;
              pc_en   = ihit;
              flush_1 = ~ihit;
            end
          end
        end
        DRAIN: begin
          flush_1 = 1'b1;
          flush_2 = 1'b1;
          flush_3 = 1'b1;
          en_4    = 1'b1;
          if (wb_halt) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALTED) && !pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt      = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl.
// Expected controls are queued at drive time and compared on the falling edge.
module tb_pipeline_ctrl;

  logic       CLK;
  logic       nRST;
  logic       ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic       id_uses_rt, ex_jump, mem_br_taken, mem_halt, wb_halt;
  logic       en_1, en_2, en_3, en_4;
  logic       flush_1, flush_2, flush_3;
  logic       pc_en, halt;
  logic [1:0] pc_sel;
  logic [15:0] stall_cnt;

  pipeline_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_jump(ex_jump), .mem_br_taken(mem_br_taken),
    .mem_halt(mem_halt), .wb_halt(wb_halt),
    .en_1(en_1), .en_2(en_2), .en_3(en_3), .en_4(en_4),
    .flush_1(flush_1), .flush_2(flush_2), .flush_3(flush_3),
    .pc_en(pc_en), .pc_sel(pc_sel), .halt(halt),
    .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {en1,en2,en3,en4,f1,f2,f3,pc_en,pc_sel[1:0],halt}
  localparam logic [10:0] NORMAL = 11'b1111_000_1_00_0;
  localparam logic [10:0] RSTV   = 11'b0000_111_0_00_0;
  localparam logic [10:0] FREEZE = 11'b0000_000_0_00_0;
  localparam logic [10:0] LU     = 11'b0011_010_0_00_0;
  localparam logic [10:0] MISS   = 11'b0111_100_0_00_0;
  localparam logic [10:0] BR     = 11'b0001_111_1_10_0;
  localparam logic [10:0] JMP    = 11'b0011_110_1_01_0;
  localparam logic [10:0] HDRAIN = 11'b0001_111_0_00_0;
  localparam logic [10:0] HALTED = 11'b0000_000_0_00_1;
  localparam logic [10:0] RSTH   = 11'b0000_111_0_00_1;

  typedef struct packed {
    logic [10:0] ctl;
    logic [15:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  logic [15:0] m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, "_ctl"},
            {21'd0, en_1, en_2, en_3, en_4, flush_1, flush_2, flush_3,
             pc_en, pc_sel, halt},
            {21'd0, e.ctl});
      check({t, "_cnt"}, {16'd0, stall_cnt}, {16'd0, e.cnt});
    end
  end

  // Queue one cycle of expectation, advance the counter model, step a cycle.
  task automatic expect_cyc(input string tag, input logic [10:0] ctl);
    exp_t e;
    e.ctl = ctl;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (!nRST) m_cnt = '0;
    else if (!ctl[3] && !ctl[0] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    ex_dREN = 1'b0; ex_wsel = '0; id_rs = '0; id_rt = '0;
    id_uses_rt = 1'b0; ex_jump = 1'b0; mem_br_taken = 1'b0;
    mem_halt = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    @(posedge CLK);
    #1;
    expect_cyc("rst", RSTV);
    nRST = 1'b1;
    expect_cyc("norm0", NORMAL);
    expect_cyc("norm1", NORMAL);

    mem_dWEN = 1'b1; dhit = 1'b1;
    expect_cyc("st_hit", NORMAL);
    mem_dWEN = 1'b0; mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) expect_cyc("dwait", FREEZE);
    dhit = 1'b1;
    expect_cyc("dadv", NORMAL);
    idle();
    expect_cyc("dwait_cnt", NORMAL);

    ex_dREN = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
    id_uses_rt = 1'b1;
    expect_cyc("lu_rt", LU);
    id_uses_rt = 1'b0;
    expect_cyc("lu_rt_unused", NORMAL);
    id_rs = 5'd5;
    expect_cyc("lu_rs", LU);
    ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    expect_cyc("lu_r0", NORMAL);
    ex_wsel = 5'd7; id_rs = 5'd7; ihit = 1'b0;
    expect_cyc("lu_over_miss", LU);
    ex_jump = 1'b1;
    expect_cyc("jmp_over_lu", JMP);
    idle();

    mem_br_taken = 1'b1; ex_jump = 1'b1;
    expect_cyc("br_jmp", BR);
    mem_br_taken = 1'b0;
    expect_cyc("jmp", JMP);
    idle();
    ihit = 1'b0;
    expect_cyc("miss", MISS);
    idle();

    mem_dREN = 1'b1; mem_br_taken = 1'b1;
    expect_cyc("br_frozen", FREEZE);
    expect_cyc("br_frozen2", FREEZE);
    dhit = 1'b1;
    expect_cyc("br_adv", BR);
    idle();
    expect_cyc("post_br", NORMAL);

    mem_halt = 1'b1;
    expect_cyc("halt_run", HDRAIN);
    mem_halt = 1'b0;
    expect_cyc("drain1", HDRAIN);
    wb_halt = 1'b1;
    expect_cyc("drain2", HDRAIN);
    wb_halt = 1'b0; ihit = 1'b0; mem_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) expect_cyc("halted", HALTED);
    idle();
    nRST = 1'b0;
    expect_cyc("rst_halted", RSTH);
    nRST = 1'b1;
    expect_cyc("post_rst", NORMAL);

    mem_dREN = 1'b1;
    expect_cyc("dw_abort", FREEZE);
    expect_cyc("dw_abort2", FREEZE);
    nRST = 1'b0;
    expect_cyc("dw_rst", RSTV);
    nRST = 1'b1; mem_dREN = 1'b0;
    expect_cyc("dw_after", NORMAL);

    ihit = 1'b0;
    for (int i = 0; i < 70000; i++) expect_cyc("sat", MISS);
    ihit = 1'b1;
    expect_cyc("sat_end", NORMAL);
    check("sat_model", {16'd0, m_cnt}, 32'd65535);

    @(negedge CLK);
    #1;
    check("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
